traffic_light_monitor: RTL and testbench
========================================

// Module: traffic_light_monitor
// PURPOSE
// - Passive observer sitting on the red/yellow/green outputs of the traffic light controller.
// - Decodes the light lines back into a phase and checks one-hot encoding, phase order
//   (RED->GREEN->YELLOW->RED) and per-phase dwell time.
// - Reports violations as one-cycle pulses plus a sticky flag, and counts clean full cycles.
// - Used in-system as a safety checker and in benches as a reusable scoreboard.
// PARAMETERS
// - RED_CYCLES     10  expected consecutive sampled cycles with red=1
// - GREEN_CYCLES    8  expected consecutive sampled cycles with green=1
// - YELLOW_CYCLES   3  expected consecutive sampled cycles with yellow=1
// - CNT_W          16  width of cycle_cnt
// PORTS
// - clk         in   1      system clock, all logic on posedge
// - rst_n       in   1      asynchronous active-low reset
// - red         in   1      red lamp line from the controller
// - yellow      in   1      yellow lamp line from the controller
// - green       in   1      green lamp line from the controller
// - clr_sticky  in   1      synchronous clear of err_sticky
// - cur_light   out  2      decoded phase: 0 NONE, 1 RED, 2 GREEN, 3 YELLOW
// - locked      out  1      monitor is synchronised to the sequence
// - err_onehot  out  1      pulse: zero or more than one lamp lit
// - err_seq     out  1      pulse: illegal phase transition
// - err_dwell   out  1      pulse: phase ended early, or overran its expected dwell
// - err_sticky  out  1      OR of all error pulses since reset or clear
// - cycle_cnt   out  CNT_W  count of clean completed RED->GREEN->YELLOW->RED cycles
// BEHAVIOUR
// - Reset (any time, including mid-phase): all outputs 0; state UNSYNC; dwell counter 0.
// - Lamps are sampled at each posedge. All outputs are registered.
// - Any violation found in the sample at posedge N is pulsed high for the cycle that follows.
// - One-hot check: a sample with 0 or >=2 lamps lit raises err_onehot for every such sample.
//   It also forces cur_light=NONE, locked=0 and state UNSYNC.
// - States: UNSYNC, T_RED, T_GREEN, T_YELLOW.
// - UNSYNC: dwell of the current phase is unknown, so nothing except one-hot is checked.
//   - Leave UNSYNC on the first sample where RED is newly seen after a non-RED sample:
//     enter T_RED, set dwell=1, set locked=1.
//   - RED held since reset does not lock.
// - T_x, same lamp sampled again: dwell++.
//   - When dwell reaches X_CYCLES+1, pulse err_dwell exactly once (overrun).
//   - The dwell counter saturates at X_CYCLES+1.
// - T_x, legal next lamp sampled: if dwell != X_CYCLES and no overrun was already reported,
//   pulse err_dwell. Then enter the next state with dwell=1.
// - T_x, illegal next lamp sampled (e.g. RED->YELLOW, GREEN->RED):
//   - pulse err_seq; enter UNSYNC with locked=0.
//   - No dwell error is reported for the phase that was interrupted.
// - Simultaneous violations in one sample: one-hot takes priority; err_seq and err_dwell
//   stay 0 for that sample.
// - cycle_cnt: +1 on a YELLOW->RED transition when the RED, GREEN and YELLOW phases just
//   completed raised no error. Wraps 2^CNT_W-1 -> 0.
// - err_sticky: set by any error pulse. clr_sticky clears it the next cycle, but an error
//   in the same cycle wins and the flag stays set.
// - Dwell counter width: $clog2(max(RED,GREEN,YELLOW)_CYCLES+2).
// STRUCTURE
// - Package traffic_light_pkg:
//   - light_e {L_NONE, L_RED, L_GREEN, L_YELLOW} (2-bit)
//   - mon_state_e
//   - default dwell constants shared with the controller
// - Sub-module traffic_light_dwell_timer:
//   - load-to-1 / increment / saturate counter
//   - outputs: match (==expected) and overrun (first reach of expected+1)
// TESTING (bench overrides RED=4, GREEN=3, YELLOW=2)
// - Clean sequence R4 G3 Y2 repeated 3x after a reset pulse
//   -> locked=1 from the first RED entry, no errors, cycle_cnt=2 after the 3rd RED entry.
// - Sample with red=1, green=1 mid-GREEN -> err_onehot for 1 cycle, locked=0;
//   resync on the next RED entry.
// - GREEN held 2 cycles, then YELLOW -> err_dwell pulse at the transition;
//   that cycle does not increment cycle_cnt.
// - YELLOW held 5 cycles -> exactly one err_dwell at the 3rd YELLOW sample;
//   no second pulse at YELLOW->RED.
// - RED->YELLOW -> err_seq pulse, locked=0; err_sticky=1 until clr_sticky,
//   then err_sticky=0.
// - rst_n dropped mid-GREEN, then released -> all outputs 0 at once;
//   relocks only at the next RED entry.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// traffic_light_pkg: lamp and monitor encodings plus default dwell times shared with the controller
package traffic_light_pkg;

    typedef enum logic [1:0] {L_NONE, L_RED, L_GREEN, L_YELLOW} light_e;
    typedef enum logic [1:0] {MS_UNSYNC, MS_RED, MS_GREEN, MS_YELLOW} mon_state_e;

    localparam int DEF_RED_CYCLES    = 10;
    localparam int DEF_GREEN_CYCLES  = 8;
    localparam int DEF_YELLOW_CYCLES = 3;

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

    // Phase order RED -> GREEN -> YELLOW -> RED
    function automatic light_e next_light(input light_e l);
        return (l == L_YELLOW) ? L_RED : light_e'(l + 2'd1);
    endfunction

endpackage

// File: rtl/traffic_light_dwell_timer.sv
// traffic_light_dwell_timer: phase dwell counter, load-to-1, increment, saturate at expected+1
module traffic_light_dwell_timer #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          load,
    input  logic          inc,
    input  logic [DW-1:0] expected,
    output logic          match,
    output logic          saturated,
    output logic          overrun
);

    logic [DW-1:0] dwell;

    assign match     = dwell == expected;
    assign saturated = dwell == expected + DW'(1);
    // Saturation means expected+1 is reached only once per phase
    assign overrun   = inc && match;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            dwell <= '0;
        else if (clear)
            dwell <= '0;
        else if (load)
            dwell <= DW'(1);
        else if (inc && !saturated)
            dwell <= dwell + DW'(1);

endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker of lamp one-hot encoding, phase order and per-phase dwell
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int RED_CYCLES    = DEF_RED_CYCLES,
    parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES,
    parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    input  logic             clr_sticky,
    output logic [1:0]       cur_light,
    output logic             locked,
    output logic             err_onehot,
    output logic             err_seq,
    output logic             err_dwell,
    output logic             err_sticky,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int DW = $clog2(max3(RED_CYCLES, GREEN_CYCLES, YELLOW_CYCLES) + 2);

    localparam logic [1:0] S_UNSYNC = MS_UNSYNC;
    localparam logic [1:0] S_RED    = MS_RED;
    localparam logic [1:0] S_GREEN  = MS_GREEN;

    logic [1:0]    state, state_n;
    logic          prev_nonred, clean;
    logic          onehot, in_t, same, legal, illegal, lock;
    logic          match, saturated, overrun;
    logic          e_one, e_seq, e_dwell, count;
    logic [DW-1:0] expected;
    light_e        lamp, nxt, st_l;

    // Tracked states share encoding with their lamp, so state and lamp compare directly
    always_comb begin
        onehot   = (2'(red) + 2'(yellow) + 2'(green)) == 2'd1;
        lamp     = !onehot ? L_NONE : red ? L_RED : green ? L_GREEN : L_YELLOW;
        st_l     = light_e'(state);
        in_t     = state != S_UNSYNC;
        nxt      = next_light(st_l);
        same     = in_t && onehot && lamp == st_l;
        legal    = in_t && onehot && lamp == nxt;
        illegal  = in_t && onehot && !same && !legal;
        lock     = !in_t && lamp == L_RED && prev_nonred;
        expected = state == S_RED ? DW'(RED_CYCLES) : state == S_GREEN ? DW'(GREEN_CYCLES) : DW'(YELLOW_CYCLES);
        e_one    = !onehot;
        e_seq    = illegal;
        e_dwell  = (same && overrun) || (legal && !match && !saturated);
        count    = legal && nxt == L_RED && clean && !e_dwell;
        state_n  = lock ? S_RED : legal ? nxt : (illegal || !onehot) ? S_UNSYNC : state;
    end

    traffic_light_dwell_timer #(.DW(DW)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (!onehot || illegal || (!in_t && !lock)),
        .load      (lock || legal),
        .inc       (same),
        .expected  (expected),
        .match     (match),
        .saturated (saturated),
        .overrun   (overrun)
    );

    // clean spans RED..YELLOW and restarts on every RED entry
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state       <= S_UNSYNC;
            prev_nonred <= 1'b0;
            clean       <= 1'b0;
            cur_light   <= 2'd0;
            locked      <= 1'b0;
            err_onehot  <= 1'b0;
            err_seq     <= 1'b0;
            err_dwell   <= 1'b0;
            err_sticky  <= 1'b0;
            cycle_cnt   <= '0;
        end else begin
            state       <= state_n;
            prev_nonred <= lamp != L_RED;
            clean       <= (lock || (legal && nxt == L_RED)) ? 1'b1 : e_dwell ? 1'b0 : clean;
            cur_light   <= lamp;
            locked      <= state_n != S_UNSYNC;
            err_onehot  <= e_one;
            err_seq     <= e_seq;
            err_dwell   <= e_dwell;
            err_sticky  <= e_one || e_seq || e_dwell || (err_sticky && !clr_sticky);
            if (count)
                cycle_cnt <= cycle_cnt + CNT_W'(1);
        end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed lamp sequences checked every cycle against a phase-level model
module tb_traffic_light_monitor;

    localparam int R = 4, G = 3, Y = 2, CW = 16;

    logic clk = 1'b0, rst_n = 1'b0;
    logic red = 1'b0, yellow = 1'b0, green = 1'b0, clr_sticky = 1'b0;
    logic [1:0] cur_light;
    logic locked, err_onehot, err_seq, err_dwell, err_sticky;
    logic [CW-1:0] cycle_cnt;

    int errors = 0, checks = 0;
    int m_sync, m_cur, m_run, m_ovr, m_clean, m_prev, m_cnt;
    int x_light, x_locked, x_one, x_seq, x_dwell, x_sticky;

    traffic_light_monitor #(
        .RED_CYCLES(R), .GREEN_CYCLES(G), .YELLOW_CYCLES(Y), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .red(red), .yellow(yellow), .green(green),
        .clr_sticky(clr_sticky), .cur_light(cur_light), .locked(locked),
        .err_onehot(err_onehot), .err_seq(err_seq), .err_dwell(err_dwell),
        .err_sticky(err_sticky), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lim(input int l);
        return l == 1 ? R : l == 2 ? G : Y;
    endfunction

    task automatic model_reset();
        m_sync = 0; m_cur = 0; m_run = 0; m_ovr = 0; m_clean = 0; m_prev = -1; m_cnt = 0;
        x_light = 0; x_locked = 0; x_one = 0; x_seq = 0; x_dwell = 0; x_sticky = 0;
    endtask

    // Lamp codes: 0 none/invalid, 1 red, 2 green, 3 yellow; the phase after l is l%3+1
    task automatic model(input int r, input int y, input int g, input int c);
        int n, l;
        n = r + y + g;
        l = (n != 1) ? 0 : r ? 1 : g ? 2 : 3;
        x_one = 0; x_seq = 0; x_dwell = 0;
        if (n != 1) begin
            x_one = 1; m_sync = 0;
        end else if (m_sync == 0) begin
            if (l == 1 && m_prev != -1 && m_prev != 1) begin
                m_sync = 1; m_cur = 1; m_run = 1; m_ovr = 0; m_clean = 1;
            end
        end else if (l == m_cur) begin
            if (m_run == lim(m_cur)) begin
                x_dwell = 1; m_ovr = 1; m_clean = 0;
            end
            if (m_run <= lim(m_cur)) m_run++;
        end else if (l == m_cur % 3 + 1) begin
            if (m_run != lim(m_cur) && m_ovr == 0) begin
                x_dwell = 1; m_clean = 0;
            end
            if (m_cur == 3) begin
                if (m_clean != 0) m_cnt = (m_cnt + 1) % (1 << CW);
                m_clean = 1;
            end
            m_cur = l; m_run = 1; m_ovr = 0;
        end else begin
            x_seq = 1; m_sync = 0;
        end
        x_sticky = (x_one != 0 || x_seq != 0 || x_dwell != 0 || (x_sticky != 0 && c == 0)) ? 1 : 0;
        x_light = l; x_locked = m_sync; m_prev = l;
    endtask

    task automatic cyc(input int r, input int y, input int g, input int c);
        red = r[0]; yellow = y[0]; green = g[0]; clr_sticky = c[0];
        @(posedge clk);
        if (rst_n) model(r, y, g, c);
        #1;
    endtask

    task automatic run(input int l, input int n);
        repeat (n) cyc(l == 1, l == 3, l == 2, 0);
    endtask

    always @(negedge clk) begin
        chk("cur_light", cur_light, x_light);
        chk("locked", locked, x_locked);
        chk("err_onehot", err_onehot, x_one);
        chk("err_seq", err_seq, x_seq);
        chk("err_dwell", err_dwell, x_dwell);
        chk("err_sticky", err_sticky, x_sticky);
        chk("cycle_cnt", cycle_cnt, m_cnt);
    end

    initial begin
        model_reset();
        red = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_locked", locked, 0);
        chk("reset_light", cur_light, 0);
        chk("reset_cnt", cycle_cnt, 0);
        run(1, 2);
        chk("red_since_reset_nolock", locked, 0);
        run(2, 1);
        run(1, 1);
        chk("lock_on_red", locked, 1);
        chk("lock_light", cur_light, 1);
        run(1, 3); run(2, 3); run(3, 2);
        run(1, 4); run(2, 3); run(3, 2);
        run(1, 1);
        chk("cnt_after_3rd_red", cycle_cnt, 2);
        chk("clean_no_sticky", err_sticky, 0);
        run(1, 3); run(2, 3); run(3, 2); run(1, 1);
        chk("cnt_3", cycle_cnt, 3);
        run(1, 3); run(2, 1);
        cyc(1, 0, 1, 0);
        chk("onehot_pulse", err_onehot, 1);
        chk("onehot_unlock", locked, 0);
        chk("onehot_light", cur_light, 0);
        chk("onehot_prio_seq", err_seq, 0);
        chk("onehot_prio_dwell", err_dwell, 0);
        run(2, 1);
        chk("onehot_one_cycle", err_onehot, 0);
        run(3, 1); run(1, 1);
        chk("relock", locked, 1);
        run(1, 3); run(2, 2); run(3, 1);
        chk("short_green", err_dwell, 1);
        run(3, 1);
        chk("short_green_once", err_dwell, 0);
        run(1, 1);
        chk("short_green_nocount", cycle_cnt, 3);
        run(1, 3); run(2, 3); run(3, 2);
        chk("y2_ok", err_dwell, 0);
        run(3, 1);
        chk("overrun_at_3rd_y", err_dwell, 1);
        run(3, 2);
        chk("overrun_once", err_dwell, 0);
        run(1, 1);
        chk("no_dwell_after_overrun", err_dwell, 0);
        chk("overrun_nocount", cycle_cnt, 3);
        run(1, 3); run(2, 3); run(3, 2); run(1, 1);
        chk("clean_again", cycle_cnt, 4);
        run(1, 1); run(3, 1);
        chk("seq_pulse", err_seq, 1);
        chk("seq_unlock", locked, 0);
        chk("seq_no_dwell", err_dwell, 0);
        chk("sticky_set", err_sticky, 1);
        run(3, 1);
        chk("sticky_hold", err_sticky, 1);
        cyc(0, 1, 0, 1);
        chk("sticky_clear", err_sticky, 0);
        cyc(1, 1, 0, 1);
        chk("clear_loses_to_error", err_sticky, 1);
        cyc(0, 0, 0, 0);
        chk("no_lamp_onehot", err_onehot, 1);
        cyc(0, 0, 1, 1);
        chk("sticky_clear2", err_sticky, 0);
        run(1, 4);
        chk("lock_before_reset", locked, 1);
        run(2, 2);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_locked", locked, 0);
        chk("async_light", cur_light, 0);
        chk("async_cnt", cycle_cnt, 0);
        chk("async_sticky", err_sticky, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run(2, 1); run(3, 1);
        chk("no_relock_before_red", locked, 0);
        run(1, 1);
        chk("relock_after_reset", locked, 1);
        run(1, 3); run(2, 3); run(3, 2); run(1, 1);
        chk("cnt_after_reset", cycle_cnt, 1);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
